// File: rtl/crc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// crc_seq_ctrl
//
// Sequencing controller for a multi-chunk CRC. A message is started with
// i_start (polynomial, seed and chunk count are latched at that moment), then
// fed one WCODE-bit chunk per accepted i_valid/o_ready handshake. Each chunk is
// folded into the running remainder through a single combinational crc_eval
// datapath, so one chunk can be taken every cycle with no stall. When the last
// chunk has been absorbed the controller spends one cycle in DONE with o_done
// high and o_crc holding the final remainder.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_start  : request to begin a message (only looked at in IDLE)
//   i_poly   : generator polynomial incl. the implicit top term (WPOLY bits)
//   i_init   : seed remainder (WPOLY-1 bits)
//   i_len    : number of chunks in the message (LENW bits)
//   i_abort  : cancel the message in progress (RUN or DONE)
//   i_data   : message chunk, MSB first
//   i_valid  : i_data is valid
//   o_ready  : a chunk is accepted this cycle when i_valid is also high
//   o_busy   : high in RUN or DONE
//   o_done   : one-cycle pulse, o_crc is final
//   o_err    : one-cycle pulse, start refused because i_poly MSB was 0
//   o_crc    : running / final remainder (WPOLY-1 bits)
// -----------------------------------------------------------------------------
module crc_seq_ctrl #(
  parameter int WCODE = 4,
  parameter int WPOLY = 4,
  parameter int LENW  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  input  logic [LENW-1:0]  i_len,
  input  logic             i_abort,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WPOLY-2:0] o_crc
);

  // Remainder width and the number of low data bits below the remainder
  // when the remainder is aligned to the MSB end of a chunk.
  localparam int R   = WPOLY - 1;
  localparam int PAD = WCODE - R;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WPOLY-1:0] poly_reg;
  logic [R-1:0]     crc_reg;
  logic [LENW-1:0]  cnt_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  // ---------------------------------------------------------------------------
  // crc_eval: remainder of d * x^R modulo poly, computed bit-serially MSB
  // first starting from the given seed. The loop unrolls into a purely
  // combinational XOR network of WCODE stages.
  // ---------------------------------------------------------------------------
  function automatic logic [R-1:0] crc_eval(
    input logic [WCODE-1:0] d,
    input logic [WPOLY-1:0] poly,
    input logic [R-1:0]     seed
  );
    logic [R-1:0] rem;
    logic         fb;
    rem = seed;
    for (int i = WCODE - 1; i >= 0; i--) begin
      fb  = d[i] ^ rem[R-1];
      rem = rem << 1;
      if (fb) begin
        rem = rem ^ poly[R-1:0];
      end
    end
    return rem;
  endfunction

  // The running remainder is folded into the top R bits of the chunk so the
  // datapath can always be evaluated from a zero seed; this is equivalent to
  // continuing the long division across chunk boundaries.
  logic [WCODE-1:0] eval_data;
  logic [R-1:0]     crc_next;
  logic             accept;

  always_comb begin
    eval_data = i_data ^ (WCODE'(crc_reg) << PAD);
    crc_next  = crc_eval(eval_data, poly_reg, '0);
  end

  // ready_reg is only ever set while in RUN, so this is the full handshake.
  assign accept = i_valid && ready_reg;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      poly_reg  <= '0;
      crc_reg   <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      // Pulses default low; each state raises them only when needed.
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          if (i_start) begin
            if (i_poly[WPOLY-1]) begin
              poly_reg <= i_poly;
              crc_reg  <= i_init;
              cnt_reg  <= i_len;
              busy_reg <= 1'b1;
              if (i_len == '0) begin
                // Empty message: the seed is the result.
                state_reg <= S_DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= S_RUN;
                ready_reg <= 1'b1;
              end
            end else begin
              // Polynomial without its top term is not a valid generator;
              // refuse the start and leave every register untouched.
              err_reg <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (i_abort) begin
            // Abort wins over a chunk presented in the same cycle; the
            // partial remainder stays visible on o_crc.
            state_reg <= S_IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (accept) begin
            crc_reg <= crc_next;
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - LENW'(1);
            end
            if (cnt_reg == LENW'(1)) begin
              state_reg <= S_DONE;
              ready_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Single-cycle state; abort would lead to the same place.
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_reg;
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;
  assign o_err   = err_reg;
  assign o_crc   = crc_reg;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crc_seq_ctrl
//
// Directed bench for crc_seq_ctrl (WCODE=4, WPOLY=4, LENW=8). The stimulus
// process pushes the hand-computed result of each message into a scoreboard
// queue; a monitor on the falling edge pops an entry whenever the DUT raises
// o_done or o_err and compares it. Timing and handshake details are checked
// inline by the stimulus process one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_crc_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_poly = '0;
  logic [2:0] i_init = '0;
  logic [7:0] i_len = '0;
  logic       i_abort = 1'b0;
  logic [3:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [2:0] o_crc;

  crc_seq_ctrl #(.WCODE(4), .WPOLY(4), .LENW(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_poly  (i_poly),
    .i_init  (i_init),
    .i_len   (i_len),
    .i_abort (i_abort),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_crc   (o_crc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         is_err;
    logic [2:0] crc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   accepts  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: one line per observed result.
  always @(negedge i_clk) begin
    if (!i_rst && i_valid && o_ready) accepts++;
    if (o_done || o_err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: done=%0b err=%0b crc=%03b, required no result", o_done, o_err, o_crc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_kind"}, {31'd0, o_err}, {31'd0, mon_e.is_err});
        check({mon_e.tag, "_crc"}, {29'd0, o_crc}, {29'd0, mon_e.crc});
        $display("txn %s: done=%0b err=%0b crc=%03b expected err=%0b crc=%03b",
                 mon_e.tag, o_done, o_err, o_crc, mon_e.is_err, mon_e.crc);
      end
    end
  end

  task automatic expect_result(input bit is_err, input logic [2:0] crc, input string tag);
    exp_t e;
    e.is_err = is_err;
    e.crc    = crc;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_msg(input logic [3:0] p, input logic [2:0] ini, input logic [7:0] len);
    i_poly  = p;
    i_init  = ini;
    i_len   = len;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Present one chunk and hold it until accepted (bounded wait).
  task automatic send_chunk(input logic [3:0] d, input string tag);
    int waited;
    waited  = 0;
    i_data  = d;
    i_valid = 1'b1;
    while (!o_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!o_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: o_ready=%0b after %0d cycles, required 1", tag, o_ready, waited);
    end
    step();
    i_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
    check({tag, "_done"},  {31'd0, o_done},  32'd0);
    check({tag, "_err"},   {31'd0, o_err},   32'd0);
    check({tag, "_crc"},   {29'd0, o_crc},   32'd0);
  endtask

  initial begin
    // Reset state.
    #1 i_rst = 1'b1;
    #1 check_all_zero("reset");
    #10 i_rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Test 1: single chunk 1101, poly 1011, seed 0 -> 001.
    expect_result(1'b0, 3'b001, "t1");
    start_msg(4'b1011, 3'b000, 8'd1);
    check("t1_ready", {31'd0, o_ready}, 32'd1);
    check("t1_busy",  {31'd0, o_busy},  32'd1);
    send_chunk(4'b1101, "t1");
    check("t1_done_latency", {31'd0, o_done}, 32'd1);
    check("t1_ready_in_done", {31'd0, o_ready}, 32'd0);
    step();
    check("t1_done_pulse", {31'd0, o_done}, 32'd0);
    check("t1_idle_busy",  {31'd0, o_busy}, 32'd0);
    check("t1_crc_hold",   {29'd0, o_crc},  32'd1);

    // Test 2: two chunks with an idle gap -> 110, exactly two accepts.
    accepts = 0;
    expect_result(1'b0, 3'b110, "t2");
    start_msg(4'b1011, 3'b000, 8'd2);
    send_chunk(4'b1101, "t2a");
    check("t2_mid_done", {31'd0, o_done}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      check("t2_gap_ready", {31'd0, o_ready}, 32'd1);
      step();
    end
    send_chunk(4'b0000, "t2b");
    check("t2_done_latency", {31'd0, o_done}, 32'd1);
    step();
    check("t2_accepts", accepts, 32'd2);

    // Test 3: empty message returns the seed one cycle after start.
    expect_result(1'b0, 3'b101, "t3");
    start_msg(4'b1011, 3'b101, 8'd0);
    check("t3_done_latency", {31'd0, o_done},  32'd1);
    check("t3_ready",        {31'd0, o_ready}, 32'd0);
    step();
    check("t3_ready_after",  {31'd0, o_ready}, 32'd0);
    check("t3_busy_after",   {31'd0, o_busy},  32'd0);

    // Test 4: polynomial without MSB -> err pulse, nothing else changes.
    expect_result(1'b1, 3'b101, "t4");
    start_msg(4'b0011, 3'b010, 8'd5);
    check("t4_err",  {31'd0, o_err},  32'd1);
    check("t4_busy", {31'd0, o_busy}, 32'd0);
    step();
    check("t4_err_pulse", {31'd0, o_err},  32'd0);
    check("t4_busy_idle", {31'd0, o_busy}, 32'd0);
    check("t4_crc_kept",  {29'd0, o_crc},  32'd5);

    // Test 5: abort together with the 2nd chunk; abort wins.
    start_msg(4'b1011, 3'b000, 8'd3);
    send_chunk(4'b1101, "t5a");
    i_data  = 4'b1111;
    i_valid = 1'b1;
    i_abort = 1'b1;
    step();
    i_valid = 1'b0;
    i_abort = 1'b0;
    check("t5_busy",    {31'd0, o_busy},  32'd0);
    check("t5_ready",   {31'd0, o_ready}, 32'd0);
    check("t5_done",    {31'd0, o_done},  32'd0);
    check("t5_partial", {29'd0, o_crc},   32'd1);
    expect_result(1'b0, 3'b001, "t5b");
    start_msg(4'b1011, 3'b000, 8'd1);
    check("t5_restart_ready", {31'd0, o_ready}, 32'd1);
    check("t5_restart_seed",  {29'd0, o_crc},   32'd0);
    send_chunk(4'b1101, "t5b");
    step();

    // Test 6: asynchronous reset mid-RUN.
    start_msg(4'b1011, 3'b000, 8'd3);
    send_chunk(4'b1101, "t6a");
    check("t6_running_crc", {29'd0, o_crc}, 32'd1);
    #2 i_rst = 1'b1;
    #1 check_all_zero("t6_async");
    i_poly  = 4'b1011;
    i_len   = 8'd1;
    i_start = 1'b1;
    i_valid = 1'b1;
    step();
    step();
    check_all_zero("t6_held");
    i_start = 1'b0;
    i_valid = 1'b0;
    #2 i_rst = 1'b0;
    step();
    check_all_zero("t6_released");

    // Recovery: a full two-chunk message after reset.
    expect_result(1'b0, 3'b110, "t7");
    start_msg(4'b1011, 3'b000, 8'd2);
    send_chunk(4'b1101, "t7a");
    send_chunk(4'b0000, "t7b");
    check("t7_done_latency", {31'd0, o_done}, 32'd1);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
